mul_hazard_ctrl: RTL and testbench
==================================

MUL_HAZARD_CTRL -- requirements
Module: mul_hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4, SHALL set the multiplier occupancy in cycles from the mul_start cycle to the mul_wb_valid cycle; legal range is 2..16.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 id_valid  in  1  decode stage holds a valid instruction.
REQ-005 id_rs1, id_rs2  in  5  decode source registers.
REQ-006 id_uses_rs1, id_uses_rs2  in  1  the source is actually read.
REQ-007 id_is_mul  in  1  the decode instruction is a multiply.
REQ-008 id_rd  in  5  decode destination register.
REQ-009 ex_valid, ex_is_load  in  1  EX holds a valid instruction, which is a load.
REQ-010 ex_rd  in  5  EX destination register.
REQ-011 flush  in  1  branch redirect; it kills the decode instruction this cycle.
REQ-012 stall_if, stall_id  out  1  hold the PC and the IF/ID register.
REQ-013 bubble_ex  out  1  inject a NOP into EX.
REQ-014 mul_start  out  1  one-cycle issue pulse to the multiplier.
REQ-015 mul_busy  out  1  the multiplier is occupied.
REQ-016 mul_rd  out  5  destination register of the in-flight multiply.
REQ-017 mul_wb_valid  out  1  one-cycle completion pulse; it is the writeback and forwarding source for mul_rd.

Function
REQ-018 Load-use hazard (luh): id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-019 When luh=1, the block SHALL combinationally drive stall_if=stall_id=bubble_ex=1 in that cycle.
REQ-020 The FSM SHALL have three states: IDLE, BUSY and WB.
REQ-021 In IDLE, id_valid & id_is_mul & !luh & !flush SHALL drive mul_start=1 and bubble_ex=1 in that cycle.
REQ-022 On that edge the block SHALL latch mul_rd=id_rd, load the counter with MUL_LAT-2 and enter BUSY.
REQ-023 In BUSY, the counter SHALL decrement each cycle; at counter==0 the FSM SHALL enter WB on the next edge.
REQ-024 In WB, mul_wb_valid SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-025 mul_busy SHALL be 1 in BUSY and WB and 0 in IDLE; mul_start-to-mul_wb_valid latency is exactly MUL_LAT-1 cycles.
REQ-026 In BUSY, a decode instruction SHALL stall (stall_if=stall_id=1, bubble_ex=1) when id_valid and any of:
  - it reads mul_rd!=0 (RAW);
  - it writes mul_rd!=0 (WAW);
  - it is a multiply (structural).
REQ-027 In WB, RAW and WAW dependents SHALL NOT stall (the result is forwarded); a multiply SHALL stall and issue in the following IDLE cycle.
REQ-028 Register x0 SHALL never create a dependency; a multiply with rd=0 SHALL still occupy the unit and pulse mul_wb_valid.
REQ-029 A flush coincident with an issue condition SHALL suppress mul_start.
REQ-030 A flush in BUSY or WB SHALL NOT abort the in-flight multiply, because it is older than the branch.
REQ-031 When luh and a BUSY stall coincide, the outputs SHALL be the OR of both; there is no double counting.

Reset
REQ-032 Assertion of rst_n=0 SHALL immediately force state=IDLE, counter=0, mul_rd=0 and mul_start=mul_wb_valid=mul_busy=0, including mid-multiply; the in-flight result is discarded.
REQ-033 During reset, stall_if, stall_id and bubble_ex SHALL be 0.

Configuration
REQ-034 With macro MUL_HAZARD_STATS_EN defined, the block SHALL add an output stall_cnt (16 bits) that increments in each cycle stall_id=1 and saturates at 0xFFFF; it resets to 0.
REQ-035 Without MUL_HAZARD_STATS_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> stall_if=stall_id=bubble_ex=1 in that cycle only.
REQ-037 Same as REQ-036 but ex_rd=0 -> no stall.
REQ-038 MUL_LAT=4, multiply with rd=7 issued at cycle 0 -> mul_start@0, mul_busy@1-3, mul_wb_valid@3 only, mul_rd=7.
REQ-039 Multiply rd=7 in flight; id_rs2=7 at cycles 1-2 -> stall at cycles 1-2, none at cycle 3 (WB); a second multiply at cycle 2 -> stalls at cycles 2-3, mul_start@4.
REQ-040 flush with an issuable multiply -> no mul_start; flush during BUSY -> mul_wb_valid still fires on time.
REQ-041 rst_n=0 at cycle 2 of a multiply -> mul_busy=0 immediately, no mul_wb_valid; with MUL_HAZARD_STATS_EN, stall_cnt=0, and 70000 stall cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/mul_hazard_ctrl.sv
// mul_hazard_ctrl: decode-stage hazard control for an in-order pipeline with
// a single iterative multiplier. Detects load-use hazards, sequences the
// multiplier through IDLE/BUSY/WB, and stalls decode on RAW/WAW/structural
// hazards against the in-flight multiply (the WB cycle forwards mul_rd).
//
// Parameter MUL_LAT (2..16): cycles from mul_start to mul_wb_valid, inclusive.
// Optional feature macro: MUL_HAZARD_STATS_EN adds the stall_cnt output.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_valid/id_rs1/id_rs2      decode instruction and its source registers
//   id_uses_rs1/id_uses_rs2     source actually read
//   id_is_mul/id_rd             decode multiply flag and destination
//   ex_valid/ex_is_load/ex_rd   EX stage instruction (load-use detection)
//   flush                       branch redirect, kills the decode instruction
//   stall_if/stall_id/bubble_ex hazard outputs (combinational)
//   mul_start                   one-cycle multiplier issue pulse (combinational)
//   mul_busy/mul_rd             multiplier occupancy and in-flight destination
//   mul_wb_valid                one-cycle completion / forwarding pulse
//   stall_cnt                   saturating stall counter (MUL_HAZARD_STATS_EN only)
module mul_hazard_ctrl #(
   parameter int unsigned MUL_LAT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       id_is_mul,
   input  logic [4:0] id_rd,
   input  logic       ex_valid,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd,
   input  logic       flush,
   output logic       stall_if,
   output logic       stall_id,
   output logic       bubble_ex,
`ifdef MUL_HAZARD_STATS_EN
   output logic [15:0] stall_cnt,
`endif
   output logic       mul_start,
   output logic       mul_busy,
   output logic [4:0] mul_rd,
   output logic       mul_wb_valid
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_dec;
   logic [REG_W-1:0] r_mul_rd;
   logic [REG_W-1:0] w_mul_rd_nxt;
   logic             r_busy;
   logic             r_wb;
   logic             w_luh;
   logic             w_raw;
   logic             w_waw;
   logic             w_issue;
   logic             w_mul_hold;
   logic             w_stall;

   // Load-use: decode reads a register a load in EX has yet to produce
   assign w_luh = id_valid & ex_valid & ex_is_load & (ex_rd != REG_W'(0)) &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                   (id_uses_rs2 & (id_rs2 == ex_rd)));

   // Dependencies on the in-flight multiply; x0 never depends
   assign w_raw = (r_mul_rd != REG_W'(0)) &
                  ((id_uses_rs1 & (id_rs1 == r_mul_rd)) |
                   (id_uses_rs2 & (id_rs2 == r_mul_rd)));
   assign w_waw = (r_mul_rd != REG_W'(0)) & (id_rd == r_mul_rd);

   assign w_cnt_dec = r_cnt - CNT_W'(1);

   // Next state, counter, destination latch and multiplier-side stall
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_mul_rd_nxt = r_mul_rd;
      w_issue      = 1'b0;
      w_mul_hold   = 1'b0;
      case (r_state)
         IDLE: begin
            if (id_valid & id_is_mul & ~w_luh & ~flush) begin
               w_issue      = 1'b1;
               w_mul_rd_nxt = id_rd;
               w_cnt_nxt    = CNT_W'(MUL_LAT - 2);
               // With the minimum latency there are no BUSY cycles at all
               w_state_nxt  = (MUL_LAT == 2) ? WB : BUSY;
            end
         end
         BUSY: begin
            w_mul_hold = id_valid & (w_raw | w_waw | id_is_mul);
            w_cnt_nxt  = w_cnt_dec;
            if (w_cnt_dec == CNT_W'(0)) begin
               w_state_nxt = WB;
            end
         end
         WB: begin
            // Result is forwarded this cycle; only a new multiply must wait
            w_mul_hold  = id_valid & id_is_mul;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register; occupancy and completion flags registered from next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_mul_rd <= '0;
         r_busy   <= 1'b0;
         r_wb     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_mul_rd <= w_mul_rd_nxt;
         r_busy   <= (w_state_nxt != IDLE);
         r_wb     <= (w_state_nxt == WB);
      end
   end

   // Combinational hazard outputs, forced quiet while reset is asserted
   assign w_stall      = rst_n & (w_luh | w_mul_hold);
   assign stall_if     = w_stall;
   assign stall_id     = w_stall;
   assign bubble_ex    = w_stall | (rst_n & w_issue);
   assign mul_start    = rst_n & w_issue;
   assign mul_busy     = r_busy;
   assign mul_rd       = r_mul_rd;
   assign mul_wb_valid = r_wb;

`ifdef MUL_HAZARD_STATS_EN
   logic [15:0] r_stall_cnt;

   // Saturating count of decode stall cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mul_hazard_ctrl.sv
// Testbench for mul_hazard_ctrl: directed scenarios plus a randomized run
// against a cycle-numbered reference model of the multiplier occupancy.
module tb_mul_hazard_ctrl;

   localparam int unsigned LAT = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic       id_is_mul;
   logic [4:0] id_rd;
   logic       ex_valid;
   logic       ex_is_load;
   logic [4:0] ex_rd;
   logic       flush;
   logic       stall_if;
   logic       stall_id;
   logic       bubble_ex;
   logic       mul_start;
   logic       mul_busy;
   logic [4:0] mul_rd;
   logic       mul_wb_valid;
`ifdef MUL_HAZARD_STATS_EN
   logic [15:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mul_hazard_ctrl #(.MUL_LAT(LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .id_is_mul    (id_is_mul),
      .id_rd        (id_rd),
      .ex_valid     (ex_valid),
      .ex_is_load   (ex_is_load),
      .ex_rd        (ex_rd),
      .flush        (flush),
      .stall_if     (stall_if),
      .stall_id     (stall_id),
      .bubble_ex    (bubble_ex),
`ifdef MUL_HAZARD_STATS_EN
      .stall_cnt    (stall_cnt),
`endif
      .mul_start    (mul_start),
      .mul_busy     (mul_busy),
      .mul_rd       (mul_rd),
      .mul_wb_valid (mul_wb_valid)
   );

   // Observed outputs as one vector: {stall_if,stall_id,bubble_ex,start,busy,wb,rd}
   wire [10:0] w_obs = {stall_if, stall_id, bubble_ex, mul_start, mul_busy, mul_wb_valid, mul_rd};

   function automatic logic [10:0] pk(input logic st, input logic bub, input logic start,
                                      input logic busy, input logic wb, input logic [4:0] rd);
      return {st, st, bub, start, busy, wb, rd};
   endfunction

   task automatic clear_in();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_is_mul = 0; id_rd = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; flush = 0;
   endtask

   task automatic test_reset();
      logic [10:0] e;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); clear_in();
         if (c < 3) begin
            rst_n = 0;
            // load-use plus issuable multiply must stay silent in reset
            id_valid = 1; id_uses_rs1 = 1; id_rs1 = 6; ex_valid = 1; ex_is_load = 1; ex_rd = 6;
            if (c == 1) begin id_uses_rs1 = 0; ex_valid = 0; end
            id_is_mul = 1; id_rd = 8;
         end else begin
            rst_n = 1;
         end
         e = pk(0, 0, 0, 0, 0, 5'd0);
         #1;
         checks++;
         if (w_obs !== e) begin
            errors++; $display("FAIL reset c%0d: got %b expected %b", c, w_obs, e);
         end
      end
   endtask

   task automatic test_load_use();
      logic [10:0] e;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); clear_in();
         e = pk(0, 0, 0, 0, 0, 5'd0);
         case (c)
            0: begin id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5; ex_valid = 1; ex_is_load = 1; ex_rd = 5;
                     e = pk(1, 1, 0, 0, 0, 5'd0); end
            1: ;
            2: begin id_valid = 1; id_uses_rs1 = 1; id_rs1 = 0; ex_valid = 1; ex_is_load = 1; ex_rd = 0; end
            3: begin id_valid = 1; id_uses_rs2 = 1; id_rs2 = 9; ex_valid = 1; ex_is_load = 1; ex_rd = 9;
                     e = pk(1, 1, 0, 0, 0, 5'd0); end
            4: begin id_valid = 1; id_uses_rs2 = 1; id_rs2 = 9; ex_valid = 1; ex_is_load = 0; ex_rd = 9; end
            5: begin id_valid = 1; id_uses_rs2 = 0; id_rs2 = 9; ex_valid = 1; ex_is_load = 1; ex_rd = 9; end
            6: begin id_valid = 0; id_uses_rs2 = 1; id_rs2 = 9; ex_valid = 1; ex_is_load = 1; ex_rd = 9; end
            default: begin id_valid = 1; id_uses_rs2 = 1; id_rs2 = 9; ex_valid = 0; ex_is_load = 1; ex_rd = 9; end
         endcase
         #1;
         checks++;
         if (w_obs !== e) begin
            errors++; $display("FAIL load_use c%0d: got %b expected %b", c, w_obs, e);
         end
      end
   endtask

   task automatic test_mul_latency();
      logic [10:0] e;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); clear_in();
         case (c)
            0: begin id_valid = 1; id_is_mul = 1; id_rd = 7; e = pk(0, 1, 1, 0, 0, 5'd0); end
            1, 2: e = pk(0, 0, 0, 1, 0, 5'd7);
            3: e = pk(0, 0, 0, 1, 1, 5'd7);
            default: e = pk(0, 0, 0, 0, 0, 5'd7);
         endcase
         #1;
         checks++;
         if (w_obs !== e) begin
            errors++; $display("FAIL mul_latency c%0d: got %b expected %b", c, w_obs, e);
         end
      end
   endtask

   task automatic test_hazards();
      logic [10:0] e;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); clear_in();
         case (c)
            0: begin id_valid = 1; id_is_mul = 1; id_rd = 7; e = pk(0, 1, 1, 0, 0, 5'd7); end
            1: begin id_valid = 1; id_uses_rs2 = 1; id_rs2 = 7; id_rd = 1; e = pk(1, 1, 0, 1, 0, 5'd7); end
            2: begin id_valid = 1; id_uses_rs2 = 1; id_rs2 = 7; id_is_mul = 1; id_rd = 3;
                     e = pk(1, 1, 0, 1, 0, 5'd7); end
            3: begin id_valid = 1; id_uses_rs2 = 1; id_rs2 = 7; id_is_mul = 1; id_rd = 3;
                     e = pk(1, 1, 0, 1, 1, 5'd7); end
            4: begin id_valid = 1; id_is_mul = 1; id_rd = 3; e = pk(0, 1, 1, 0, 0, 5'd7); end
            5: begin id_valid = 1; id_rd = 3; e = pk(1, 1, 0, 1, 0, 5'd3); end
            6: begin id_valid = 1; id_uses_rs1 = 1; id_rs1 = 3; ex_valid = 1; ex_is_load = 1; ex_rd = 3;
                     e = pk(1, 1, 0, 1, 0, 5'd3); end
            7: begin id_valid = 1; id_uses_rs1 = 1; id_rs1 = 3; id_rd = 3; e = pk(0, 0, 0, 1, 1, 5'd3); end
            8: begin id_valid = 1; id_uses_rs1 = 1; id_rs1 = 3; e = pk(0, 0, 0, 0, 0, 5'd3); end
            default: begin id_valid = 1; id_is_mul = 1; id_rd = 4; id_uses_rs1 = 1; id_rs1 = 2;
                     ex_valid = 1; ex_is_load = 1; ex_rd = 2; e = pk(1, 1, 0, 0, 0, 5'd3); end
         endcase
         #1;
         checks++;
         if (w_obs !== e) begin
            errors++; $display("FAIL hazards c%0d: got %b expected %b", c, w_obs, e);
         end
      end
   endtask

   task automatic test_flush();
      logic [10:0] e;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); clear_in();
         case (c)
            0: begin id_valid = 1; id_is_mul = 1; id_rd = 9; flush = 1; e = pk(0, 0, 0, 0, 0, 5'd3); end
            1: begin id_valid = 1; id_is_mul = 1; id_rd = 9; e = pk(0, 1, 1, 0, 0, 5'd3); end
            2, 3: begin flush = 1; e = pk(0, 0, 0, 1, 0, 5'd9); end
            4: begin flush = 1; e = pk(0, 0, 0, 1, 1, 5'd9); end
            default: e = pk(0, 0, 0, 0, 0, 5'd9);
         endcase
         #1;
         checks++;
         if (w_obs !== e) begin
            errors++; $display("FAIL flush c%0d: got %b expected %b", c, w_obs, e);
         end
      end
   endtask

   task automatic test_x0();
      logic [10:0] e;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); clear_in();
         case (c)
            0: begin id_valid = 1; id_is_mul = 1; id_rd = 0; e = pk(0, 1, 1, 0, 0, 5'd9); end
            1, 2: begin id_valid = 1; id_uses_rs1 = 1; id_uses_rs2 = 1; e = pk(0, 0, 0, 1, 0, 5'd0); end
            3: e = pk(0, 0, 0, 1, 1, 5'd0);
            default: e = pk(0, 0, 0, 0, 0, 5'd0);
         endcase
         #1;
         checks++;
         if (w_obs !== e) begin
            errors++; $display("FAIL x0 c%0d: got %b expected %b", c, w_obs, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] e;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk); clear_in();
         case (c)
            0: begin id_valid = 1; id_is_mul = 1; id_rd = 12; e = pk(0, 1, 1, 0, 0, 5'd0); end
            1: e = pk(0, 0, 0, 1, 0, 5'd12);
            2, 3: begin rst_n = 0; id_valid = 1; id_is_mul = 1; id_rd = 12;
                        e = pk(0, 0, 0, 0, 0, 5'd0); end
            default: begin rst_n = 1; e = pk(0, 0, 0, 0, 0, 5'd0); end
         endcase
         #1;
         checks++;
         if (w_obs !== e) begin
            errors++; $display("FAIL reset_mid c%0d: got %b expected %b", c, w_obs, e);
         end
      end
   endtask

   // Reference model: an in-flight multiply issued at cycle t writes back at
   // cycle t+LAT-1; before that it is "busy", at that cycle it forwards.
   task automatic test_random();
      bit          m_act = 0;
      int          m_wb = 0;
      logic [4:0]  m_rd = 0;
      logic [10:0] e;
      bit          luh, bsy, wbp, dep, hold, start, st;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rst_n       = ($urandom_range(0, 79) != 0);
         id_valid    = ($urandom_range(0, 3) != 0);
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_uses_rs1 = 1'($urandom_range(0, 1));
         id_uses_rs2 = 1'($urandom_range(0, 1));
         id_is_mul   = ($urandom_range(0, 2) == 0);
         id_rd       = 5'($urandom_range(0, 3));
         ex_valid    = 1'($urandom_range(0, 1));
         ex_is_load  = ($urandom_range(0, 3) == 0);
         ex_rd       = 5'($urandom_range(0, 3));
         flush       = ($urandom_range(0, 7) == 0);
         if (!rst_n) begin
            m_act = 0; m_rd = 0;
            e = pk(0, 0, 0, 0, 0, 5'd0);
         end else begin
            luh   = id_valid && ex_valid && ex_is_load && ex_rd != 0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
            bsy   = m_act && (c < m_wb);
            wbp   = m_act && (c == m_wb);
            dep   = (m_rd != 0) && ((id_uses_rs1 && id_rs1 == m_rd) ||
                                    (id_uses_rs2 && id_rs2 == m_rd) || (id_rd == m_rd));
            hold  = id_valid && ((bsy && (dep || id_is_mul)) || (wbp && id_is_mul));
            start = !m_act && id_valid && id_is_mul && !luh && !flush;
            st    = luh || hold;
            e     = pk(st, st || start, start, m_act, wbp, m_rd);
            if (start) begin
               m_act = 1; m_wb = c + int'(LAT) - 1; m_rd = id_rd;
            end else if (wbp) begin
               m_act = 0;
            end
         end
         #1;
         checks++;
         if (w_obs !== e) begin
            errors++; $display("FAIL random c%0d: got %b expected %b", c, w_obs, e);
         end
      end
      @(negedge clk); clear_in(); rst_n = 0;
      @(negedge clk); rst_n = 1;
   endtask

`ifdef MUL_HAZARD_STATS_EN
   task automatic test_stats();
      logic [15:0] e;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); clear_in();
         rst_n = (c != 0);
         case (c)
            0: e = 16'd0;
            1: begin
               id_valid = 1; id_uses_rs1 = 1; id_rs1 = 4; ex_valid = 1; ex_is_load = 1; ex_rd = 4;
               repeat (10) @(posedge clk);
               e = 16'd10;
            end
            2: begin
               id_valid = 1; id_uses_rs1 = 1; id_rs1 = 4; ex_valid = 1; ex_is_load = 1; ex_rd = 4;
               repeat (70000) @(posedge clk);
               e = 16'hFFFF;
            end
            3: begin
               id_valid = 1; id_uses_rs1 = 1; id_rs1 = 4; ex_valid = 1; ex_is_load = 1; ex_rd = 4;
               repeat (3) @(posedge clk);
               e = 16'hFFFF;
            end
            default: begin rst_n = 0; e = 16'd0; end
         endcase
         #1;
         checks++;
         if (stall_cnt !== e) begin
            errors++; $display("FAIL stats c%0d: got %h expected %h", c, stall_cnt, e);
         end
      end
      @(negedge clk); rst_n = 1;
   endtask
`endif

   initial begin
      rst_n = 0;
      clear_in();
      test_reset();
      test_load_use();
      test_mul_latency();
      test_hazards();
      test_flush();
      test_x0();
      test_reset_mid();
      test_random();
`ifdef MUL_HAZARD_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
